// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem decoder: sequencer states and default constants.
package iomem_pkg;

  // Sequencer states: waiting for a request, waiting on a slave, answering the CPU.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Address byte addr[31:24] that selects the peripheral I/O window.
  localparam logic [7:0]  REGION_IO        = 8'h03;

  // Read data returned for unmapped or timed-out accesses.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_timeout.sv
// Watchdog counter for a pending slave access. It counts cycles while enabled and
// flags expiry on the last allowed cycle. The count saturates there and never wraps.
module iomem_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned    CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign expire  = enable && at_last;

  // Next count: clear wins, otherwise step while enabled and short of the limit.
  always_comb begin
    // NOTE: give every combinationally assigned signal a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !at_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iomem_decoder.sv
// Address decoder and response sequencer for the picosoc iomem bus. Each access in
// the REGION window is registered and presented to exactly one slave; unmapped slots
// and slaves that never answer are ended with ERR_DATA so the CPU cannot hang.
module iomem_decoder
  import iomem_pkg::*;
#(
  parameter int unsigned N_SLAVES       = 4,
  parameter logic [7:0]  REGION         = REGION_IO,
  parameter int unsigned SEL_LSB        = 20,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  // CPU side
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  // Peripheral side
  output logic [N_SLAVES-1:0]      s_valid,
  input  logic [N_SLAVES-1:0]      s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  // Error reporting
  output logic                     err_pulse,
  output logic [31:0]              err_addr
);

  state_e                state_q, state_d;
  logic [N_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic [3:0]            s_wstrb_q, s_wstrb_d;
  logic [31:0]           s_addr_q, s_addr_d;
  logic [31:0]           s_wdata_q, s_wdata_d;
  logic                  m_ready_q, m_ready_d;
  logic [31:0]           m_rdata_q, m_rdata_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [SEL_W-1:0]      m_slot;
  logic [N_SLAVES-1:0]   m_onehot;
  logic                  slot_ok;
  logic                  region_hit;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  tmo_clear;
  logic                  tmo_enable;
  logic                  tmo_expire;

  // Slot decode: a slot at or beyond N_SLAVES shifts its bit out, leaving an all-zero mask.
  assign m_slot     = m_addr[SEL_LSB +: SEL_W];
  assign m_onehot   = N_SLAVES'(1) << m_slot;
  assign slot_ok    = |m_onehot;
  assign region_hit = (m_addr[31:24] == REGION);

  // Response select driven by the registered one-hot request, so unselected ready bits drop out.
  always_comb begin
    sel_ready = |(s_ready & s_valid_q);
    sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_valid_q[k]) begin
        sel_rdata = sel_rdata | s_rdata[32*k +: 32];
      end
    end
  end

  // Watchdog runs only while a slave is pending and has not answered this cycle.
  assign tmo_clear  = (state_q != ST_BUSY);
  assign tmo_enable = (state_q == ST_BUSY) && !sel_ready;

  iomem_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Next-state and registered-output logic for the IDLE -> BUSY -> RESP sequencer.
  always_comb begin
    state_d     = state_q;
    s_valid_d   = s_valid_q;
    s_wstrb_d   = s_wstrb_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_ready_d   = 1'b0;
    m_rdata_d   = m_rdata_q;
    err_pulse_d = 1'b0;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        // The !m_ready term skips the cycle in which the previous response is still visible.
        if (m_valid && !m_ready_q && region_hit) begin
          if (slot_ok) begin
            s_valid_d = m_onehot;
            s_wstrb_d = m_wstrb;
            s_addr_d  = m_addr;
            s_wdata_d = m_wdata;
            state_d   = ST_BUSY;
          end else begin
            m_rdata_d   = ERR_DATA;
            err_pulse_d = 1'b1;
            err_addr_d  = m_addr;
            state_d     = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        // A slave answer on the expiry cycle still counts as a normal completion.
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          s_valid_d = '0;
          state_d   = ST_RESP;
        end else if (tmo_expire) begin
          m_rdata_d   = ERR_DATA;
          s_valid_d   = '0;
          err_pulse_d = 1'b1;
          err_addr_d  = s_addr_q;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        m_ready_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        s_valid_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      s_valid_q   <= '0;
      s_wstrb_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_valid_q   <= s_valid_d;
      s_wstrb_q   <= s_wstrb_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign m_rdata   = m_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_wstrb   = s_wstrb_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign err_pulse = err_pulse_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_iomem_decoder.sv
// Self-checking bench for iomem_decoder: directed vector table, reset-abort sequence,
// and randomized accesses checked against a rule-level reference model.
module tb_iomem_decoder;

  localparam int          NS       = 3;
  localparam int          TO       = 16;
  localparam logic [31:0] ERR      = 32'hDEAD_BEEF;
  localparam int          BOUND    = 30;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                m_valid = 1'b0;
  logic                m_ready;
  logic [3:0]          m_wstrb = '0;
  logic [31:0]         m_addr = '0;
  logic [31:0]         m_wdata = '0;
  logic [31:0]         m_rdata;
  logic [NS-1:0]       s_valid;
  logic [NS-1:0]       s_ready;
  logic [3:0]          s_wstrb;
  logic [31:0]         s_addr;
  logic [31:0]         s_wdata;
  logic [32*NS-1:0]    s_rdata;
  logic                err_pulse;
  logic [31:0]         err_addr;

  always #5 clk = ~clk;

  iomem_decoder #(
    .N_SLAVES       (NS),
    .REGION         (8'h03),
    .SEL_LSB        (20),
    .SEL_W          (2),
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (ERR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_wstrb   (m_wstrb),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_wstrb   (s_wstrb),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .err_pulse (err_pulse),
    .err_addr  (err_addr)
  );

  // Slave models: slave k raises ready lat_cfg[k] cycles after its request appears
  // (0 = same cycle, negative = never); junk forces stray ready bits.
  int            lat_cfg [NS];
  logic [31:0]   rd_cfg  [NS];
  int            cyc     [NS];
  logic [NS-1:0] junk = '0;

  initial begin
    for (int k = 0; k < NS; k++) begin
      lat_cfg[k] = -1;
      rd_cfg[k]  = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) cyc[k] <= s_valid[k] ? cyc[k] + 1 : 0;
  end

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int k = 0; k < NS; k++) begin
      s_ready[k] = junk[k] | (s_valid[k] && lat_cfg[k] >= 0 && cyc[k] >= lat_cfg[k]);
      s_rdata[32*k +: 32] = rd_cfg[k];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          responds;  // any m_ready at all
    logic [NS-1:0] sv;        // one-hot request the slaves should see
    int            lat;       // clock edges from accept edge to m_ready visible
    logic [31:0]   rdata;
    logic          err;
  } exp_t;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    int            lat;
    logic [31:0]   data;
    logic [NS-1:0] junk;
    exp_t          e;
  } vec_t;

  // Reference model from the access rules: region match, slot range, slave delay vs watchdog.
  function automatic exp_t model(input logic [31:0] addr, input int lat, input logic [31:0] data);
    exp_t r;
    int   region = int'(addr >> 24);
    int   slot   = int'((addr >> 20) % 4);
    r.responds = 1'b1;
    r.sv = '0;
    r.err = 1'b0;
    r.rdata = data;
    r.lat = 0;
    if (region != 3) begin
      r.responds = 1'b0;
    end else if (slot >= NS) begin
      r.err = 1'b1; r.rdata = ERR; r.lat = 1;
    end else begin
      r.sv = NS'(1 << slot);
      if (lat < 0 || lat >= TO) begin
        r.err = 1'b1; r.rdata = ERR; r.lat = TO + 1;
      end else begin
        r.lat = lat + 2;
      end
    end
    return r;
  endfunction

  // Run one CPU access; called one step after a clock edge with m_ready low.
  task automatic run_txn(input vec_t v, input string tag);
    int   slot = int'(v.addr[21:20]);
    int   seen = 99;
    int   sv_cycles = 0;
    int   bad_sv = 0;
    int   bad_bus = 0;
    int   err_cnt = 0;
    int   rdy_cnt = 0;
    logic [31:0] got_rdata = 'x;
    logic [31:0] got_eaddr = 'x;
    for (int k = 0; k < NS; k++) begin
      lat_cfg[k] = -1;
      rd_cfg[k]  = ~v.data ^ 32'(k);
    end
    if (slot < NS) begin
      lat_cfg[slot] = v.lat;
      rd_cfg[slot]  = v.data;
    end
    junk    = v.junk;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_wstrb = v.wstrb;
    m_valid = 1'b1;
    for (int n = 0; n < BOUND; n++) begin
      @(posedge clk); #1;
      if (s_valid != '0) begin
        sv_cycles++;
        if (s_valid !== v.e.sv) bad_sv++;
        if (s_addr !== v.addr || s_wdata !== v.wdata || s_wstrb !== v.wstrb) bad_bus++;
      end
      if (err_pulse) begin
        err_cnt++;
        got_eaddr = err_addr;
      end
      if (m_ready) begin
        rdy_cnt++;
        if (seen == 99) begin
          seen = n;
          got_rdata = m_rdata;
        end
        if (v.e.responds) break;
      end
    end
    m_valid = 1'b0;
    junk = '0;
    if (v.e.responds) begin
      check({tag, " latency"}, 32'(seen), 32'(v.e.lat));
      check({tag, " m_rdata"}, got_rdata, v.e.rdata);
      check({tag, " err_pulse count"}, 32'(err_cnt), v.e.err ? 32'd1 : 32'd0);
      check({tag, " s_valid cycles"}, 32'(sv_cycles), 32'(v.e.lat - 1));
      check({tag, " s_valid one-hot"}, 32'(bad_sv), 32'd0);
      check({tag, " s_bus stable"}, 32'(bad_bus), 32'd0);
      if (v.e.err) check({tag, " err_addr"}, got_eaddr, v.addr);
      @(posedge clk); #1;
      check({tag, " m_ready width"}, {31'd0, m_ready}, 32'd0);
      check({tag, " m_rdata hold"}, m_rdata, v.e.rdata);
    end else begin
      check({tag, " ignored m_ready"}, 32'(rdy_cnt), 32'd0);
      check({tag, " ignored s_valid"}, 32'(sv_cycles), 32'd0);
      check({tag, " ignored err"}, 32'(err_cnt), 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int lat, input logic [31:0] data,
                              input logic [NS-1:0] jk, input logic resp, input logic [NS-1:0] sv,
                              input int elat, input logic [31:0] erd, input logic err);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.lat = lat; v.data = data; v.junk = jk;
    v.e.responds = resp; v.e.sv = sv; v.e.lat = elat; v.e.rdata = erd; v.e.err = err;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;

    vecs.push_back(mk(32'h0310_0004, 32'h0,         4'b0000,  1, 32'h1234_5678, 3'b000, 1, 3'b010,  3, 32'h1234_5678, 0));
    vecs.push_back(mk(32'h0300_0000, 32'hA5A5_5A5A, 4'b0011,  2, 32'h0000_1111, 3'b000, 1, 3'b001,  4, 32'h0000_1111, 0));
    vecs.push_back(mk(32'h0330_0000, 32'h0,         4'b0000,  0, 32'hCAFE_0000, 3'b000, 1, 3'b000,  1, ERR,           1));
    vecs.push_back(mk(32'h0320_0000, 32'h0,         4'b0000, -1, 32'h2222_0000, 3'b000, 1, 3'b100, 17, ERR,           1));
    vecs.push_back(mk(32'h0320_0004, 32'h0,         4'b0000, 15, 32'h3333_4444, 3'b000, 1, 3'b100, 17, 32'h3333_4444, 0));
    vecs.push_back(mk(32'h0320_0008, 32'h0,         4'b0000, 14, 32'h5555_6666, 3'b000, 1, 3'b100, 16, 32'h5555_6666, 0));
    vecs.push_back(mk(32'h0200_0000, 32'h0,         4'b0000,  0, 32'h0BAD_0BAD, 3'b111, 0, 3'b000,  0, 32'h0,         0));
    vecs.push_back(mk(32'h0300_0020, 32'h0,         4'b0000,  3, 32'h7777_8888, 3'b110, 1, 3'b001,  5, 32'h7777_8888, 0));
    vecs.push_back(mk(32'h0310_0000, 32'hFFFF_0000, 4'b1111,  0, 32'h9999_AAAA, 3'b000, 1, 3'b010,  2, 32'h9999_AAAA, 0));
    vecs.push_back(mk(32'h03F0_0000, 32'h0,         4'b0000,  0, 32'h1111_2222, 3'b000, 1, 3'b000,  1, ERR,           1));
    vecs.push_back(mk(32'h0420_0000, 32'h0,         4'b0000,  0, 32'h4444_5555, 3'b000, 0, 3'b000,  0, 32'h0,         0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset s_valid",   32'(s_valid), 32'd0);
    check("reset m_ready",   {31'd0, m_ready}, 32'd0);
    check("reset m_rdata",   m_rdata, 32'd0);
    check("reset err_pulse", {31'd0, err_pulse}, 32'd0);
    check("reset err_addr",  err_addr, 32'd0);
    check("reset s_addr",    s_addr, 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a slave is pending: request drops at once, no response, then normal service.
    for (int k = 0; k < NS; k++) lat_cfg[k] = -1;
    m_addr = 32'h0300_0010; m_wdata = 32'h0; m_wstrb = 4'b0000; m_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy s_valid", 32'(s_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid-reset s_valid", 32'(s_valid), 32'd0);
    check("mid-reset m_ready", {31'd0, m_ready}, 32'd0);
    check("mid-reset err_pulse", {31'd0, err_pulse}, 32'd0);
    m_valid = 1'b0;
    @(posedge clk); #1;
    check("in-reset m_ready", {31'd0, m_ready}, 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    run_txn(mk(32'h0300_0040, 32'h0, 4'b0000, 0, 32'h600D_F00D, 3'b000, 1, 3'b001, 2, 32'h600D_F00D, 0), "post-reset");

    // Randomized accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  region;
      int          sel;
      int          slot;
      v.wdata = $urandom;
      v.wstrb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      region = 8'h03;
      if ($urandom_range(0, 9) == 0) begin
        region = 8'($urandom_range(0, 255));
        if (region == 8'h03) region = 8'h04;
      end
      v.addr = {region, 24'($urandom)};
      sel = $urandom_range(0, 7);
      if (sel <= 4)       v.lat = $urandom_range(0, 5);
      else if (sel == 5)  v.lat = 14;
      else if (sel == 6)  v.lat = $urandom_range(15, 16);
      else                v.lat = -1;
      v.data = $urandom;
      slot = int'(v.addr[21:20]);
      v.junk = NS'($urandom);
      if (slot < NS) v.junk[slot] = 1'b0;
      v.e = model(v.addr, v.lat, v.data);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
